// File: rtl/riscv_iter_divider_if.sv
// Request/response bundle between the ALU and the iterative divider.
// The ALU is the master: it drives the operands and the start strobe.
interface riscv_iter_divider_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             invalid;
  logic             Signed;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] result_REM;
  logic             ovalid;
  logic             busy;

  modport master (
    output dividend, divisor, invalid, Signed,
    input  quotient, result_REM, ovalid, busy
  );

  modport slave (
    input  dividend, divisor, invalid, Signed,
    output quotient, result_REM, ovalid, busy
  );
endinterface

// File: rtl/riscv_iter_divider.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and finish in one step.
module riscv_iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_iter_divider_if.slave  io_div
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [CntW-1:0]  r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_ovalid;

  logic             w_accept;
  logic             w_fix;
  logic             w_busy;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_special;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_div_zero = (io_div.divisor == '0);
  assign w_overflow = io_div.Signed && (io_div.dividend == MinNeg) && (io_div.divisor == '1);
  assign w_special  = w_div_zero || w_overflow;
  assign w_a_neg    = io_div.Signed && io_div.dividend[WIDTH-1];
  assign w_b_neg    = io_div.Signed && io_div.divisor[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -io_div.dividend : io_div.dividend;
  assign w_b_abs    = w_b_neg ? -io_div.divisor : io_div.divisor;

  // Extra top bit keeps the compare exact when the divisor magnitude is 2^(WIDTH-1) or more.
  assign w_rem_sh   = {r_rem, r_a[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (io_div.invalid) w_state_next = w_special ? StFix : StCalc;
      StCalc: if (r_cnt == CntLast) w_state_next = StFix;
      StFix:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_accept = (r_state == StIdle) && io_div.invalid;
    w_fix    = (r_state == StFix);
    w_busy   = (r_state != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_ovalid  <= 1'b0;
    end else begin
      r_ovalid <= w_fix;
      if (w_accept) begin
        r_cnt <= '0;
        r_b   <= w_b_abs;
        // Special results are parked in the quotient/remainder registers with no sign fix-up.
        if (w_div_zero) begin
          r_a     <= '1;
          r_rem   <= io_div.dividend;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else if (w_overflow) begin
          r_a     <= MinNeg;
          r_rem   <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else begin
          r_a     <= w_a_abs;
          r_rem   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
        end
      end else if (r_state == StCalc) begin
        r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
        r_a   <= {r_a[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end else if (w_fix) begin
        r_quot    <= r_neg_q ? -r_a : r_a;
        r_rem_out <= r_neg_r ? -r_rem : r_rem;
      end
    end
  end

  assign io_div.quotient   = r_quot;
  assign io_div.result_REM = r_rem_out;
  assign io_div.ovalid     = r_ovalid;
  assign io_div.busy       = w_busy;

endmodule
